// File: rtl/product_accumulator.sv
// Burst accumulator: sums LEN signed products from the upstream multiplier into a
// saturating ACC_W-bit accumulator and holds the result until downstream takes it.
module product_accumulator #(
    parameter int ACC_W = 10,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] LEN,
    input  logic [7:0]       PRODUCT,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [ACC_W-1:0] ACC,
    output logic             SAT,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    // Handshakes: a product moves on a rising edge where in_valid && in_ready; the
    // result is consumed on a rising edge where out_valid && out_ready. Both ready and
    // valid outputs are registered, so neither depends on the partner's input.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_t           state;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] cnt_nxt;
    logic [ACC_W:0]   sum;
    logic             ovf_pos;
    logic             ovf_neg;
    logic [ACC_W-1:0] acc_sat;

    // One guard bit is enough: adding an 8-bit value to an ACC_W-bit value never
    // overflows ACC_W+1 bits, so the top two bits disagreeing flags the clamp case.
    assign sum     = {ACC[ACC_W-1], ACC} + {{(ACC_W-7){PRODUCT[7]}}, PRODUCT};
    assign ovf_pos = ~sum[ACC_W] & sum[ACC_W-1];
    assign ovf_neg = sum[ACC_W] & ~sum[ACC_W-1];
    assign acc_sat = ovf_pos ? ACC_MAX : (ovf_neg ? ACC_MIN : sum[ACC_W-1:0]);
    assign cnt_nxt = cnt + LEN_W'(1);

    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            len_q     <= '0;
            cnt       <= '0;
            ACC       <= '0;
            SAT       <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        len_q <= LEN;
                        cnt   <= '0;
                        ACC   <= '0;
                        SAT   <= 1'b0;
                        busy  <= 1'b1;
                        if (LEN != '0) begin
                            state    <= ACCUM;
                            in_ready <= 1'b1;
                        end else begin
                            state     <= HOLD;
                            out_valid <= 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        ACC <= acc_sat;
                        SAT <= SAT | ovf_pos | ovf_neg;
                        cnt <= cnt_nxt;
                        if (cnt_nxt == len_q) begin
                            state     <= HOLD;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 Parameter: ACC_W, 10, accumulator width in bits (signed, two's complement).
REQ-002 Parameter: LEN_W, 4, width of the burst-length field.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port: start  input  1  one-cycle request to begin a burst; sampled only in IDLE.
REQ-006 Port: LEN  input  LEN_W  number of products to accumulate (0..15); captured when start is accepted.
REQ-007 Port: PRODUCT  input  8  signed product from the upstream Booth multiplier.
REQ-008 Port: in_valid  input  1  PRODUCT is valid this cycle.
REQ-009 Port: in_ready  output  1  block accepts PRODUCT this cycle.
REQ-010 Port: ACC  output  ACC_W  signed accumulated result.
REQ-011 Port: SAT  output  1  sticky flag: saturation occurred during the current burst.
REQ-012 Port: out_valid  output  1  ACC/SAT hold a completed burst result.
REQ-013 Port: out_ready  input  1  downstream consumes the result.
REQ-014 Port: busy  output  1  high in any state other than IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, ACCUM and HOLD.
REQ-016 IDLE: in_ready=0, out_valid=0; on start=1, capture LEN, clear ACC, SAT and the count; go to ACCUM if LEN!=0, otherwise go to HOLD with ACC=0.
REQ-017 ACCUM: in_ready=1; a transfer occurs when in_valid && in_ready at the rising edge; no transfer means no state change.
REQ-018 On each transfer, ACC SHALL become sat(ACC + sign-extended PRODUCT) and the count SHALL increment.
REQ-019 Saturation: results above 2^(ACC_W-1)-1 clamp to that value; results below -2^(ACC_W-1) clamp to that value; either case sets SAT, which stays set until the next accepted start or reset.
REQ-020 The transfer that brings the count to LEN SHALL move the FSM to HOLD at the same edge, so out_valid=1 in the next cycle (latency: 1 cycle from the last transfer edge).
REQ-021 HOLD: out_valid=1, in_ready=0; ACC and SAT SHALL stay stable until out_ready=1 is sampled, then go to IDLE (out_valid=0 in the next cycle).
REQ-022 start outside IDLE SHALL be ignored, including start asserted in the same cycle as the HOLD handshake; a new burst requires start in IDLE.
REQ-023 PRODUCT/in_valid outside ACCUM SHALL be ignored and SHALL NOT affect ACC.
REQ-024 ACC SHALL retain the last result in IDLE until the next accepted start.
REQ-025 in_ready and out_valid SHALL be decoded from registered state only, with no combinational path from in_valid or out_ready.

Reset
REQ-026 With rst_n=0 at a rising edge, the block SHALL enter IDLE with ACC=0, SAT=0, count=0, in_ready=0, out_valid=0 and busy=0, regardless of the current state (including mid-ACCUM and HOLD).
REQ-027 The first start is honoured on the first edge at which rst_n=1 and start=1.

Verification
REQ-028 Basic: start, LEN=4, four transfers of PRODUCT=18 (6*3) -> out_valid=1 one cycle after the 4th transfer, ACC=72, SAT=0.
REQ-029 Backpressure/gaps: LEN=3, products 5, -7, 12 with in_valid low for 2 cycles between transfers; out_ready held low 3 cycles -> ACC=10, out_valid and ACC stable throughout HOLD, IDLE the cycle after out_ready=1.
REQ-030 Saturation: LEN=15, PRODUCT=127 each -> ACC=511, SAT=1; LEN=5, PRODUCT=-128 each -> ACC=-512, SAT=1.
REQ-031 LEN=0: start with LEN=0 -> HOLD next cycle, ACC=0, SAT=0, no transfers accepted (in_ready never 1).
REQ-032 Reset mid-burst: rst_n=0 after 2 of 4 transfers -> next edge ACC=0, busy=0, out_valid=0; a following burst LEN=2 of 9 and -3 yields ACC=6.
REQ-033 Ignored start: start pulsed during ACCUM and in the same cycle as the HOLD handshake -> LEN and ACC are unaffected and the block is in IDLE afterwards.
